// File: rtl/mlp_weight_reader.sv
// Read-side sequencer for the MLP weight memory: streams a contiguous block of
// weights to the MAC datapath over valid/ready, repeated for num_passes passes.
module mlp_weight_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic                  w_pass_last
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         nwords_q;
  logic [PASS_WIDTH-1:0] npasses_q;
  logic [CW-1:0]         word_cnt_q;
  logic [PASS_WIDTH-1:0] pass_cnt_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  w_valid_q;
  logic                  w_last_q;
  logic                  w_pass_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic fetch;
  logic is_last_word;
  logic is_last_pass;

  // The output register is free when empty or being drained this edge.
  assign fetch        = (state_q == RUN) && (!w_valid_q || w_ready);
  assign is_last_word = (word_cnt_q == nwords_q - CW'(1));
  assign is_last_pass = (pass_cnt_q == npasses_q - PASS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      nwords_q      <= '0;
      npasses_q     <= '0;
      word_cnt_q    <= '0;
      pass_cnt_q    <= '0;
      mem_addr_q    <= '0;
      w_data_q      <= '0;
      w_valid_q     <= 1'b0;
      w_last_q      <= 1'b0;
      w_pass_last_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            nwords_q   <= num_words;
            npasses_q  <= num_passes;
            mem_addr_q <= base_addr;
            word_cnt_q <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (num_words == '0 || num_passes == '0)
              state_q <= FINISH;
            else
              state_q <= RUN;
          end
        end
        RUN: begin
          if (fetch) begin
            w_data_q      <= mem_rd_data;
            w_valid_q     <= 1'b1;
            w_last_q      <= is_last_word;
            w_pass_last_q <= is_last_word && is_last_pass;
            if (is_last_word) begin
              // Reload the block start so the next pass follows without a bubble.
              word_cnt_q <= '0;
              pass_cnt_q <= pass_cnt_q + PASS_WIDTH'(1);
              mem_addr_q <= base_q;
              if (is_last_pass)
                state_q <= DRAIN;
            end else begin
              word_cnt_q <= word_cnt_q + CW'(1);
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (w_ready) begin
            w_valid_q     <= 1'b0;
            w_last_q      <= 1'b0;
            w_pass_last_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= FINISH;
          end
        end
        FINISH: begin
          // Empty jobs arrive here still busy; they get their done pulse first.
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_addr    = mem_addr_q;
  assign w_data      = w_data_q;
  assign w_valid     = w_valid_q;
  assign w_last      = w_last_q;
  assign w_pass_last = w_pass_last_q;

endmodule

// File: tb/tb_mlp_weight_reader.sv
// Directed bench for mlp_weight_reader with a combinational weight memory model
// holding 16'h0100 + address at every location.
module tb_mlp_weight_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  num_words;
  logic [7:0]  num_passes;
  logic        busy;
  logic        done;
  logic [5:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic        w_pass_last;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_data[$];
  bit          exp_last[$];
  bit          exp_plast[$];
  logic [15:0] got_data[$];
  bit          got_last[$];
  bit          got_plast[$];
  bit          rdy_pat[$];
  int          poke_at = -1;

  mlp_weight_reader #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(16),
    .PASS_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .num_passes (num_passes),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_last     (w_last),
    .w_pass_last(w_pass_last)
  );

  assign mem_rd_data = 16'h0100 + {10'd0, mem_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_exp(input logic [15:0] d, input bit l, input bit pl);
    exp_data.push_back(d);
    exp_last.push_back(l);
    exp_plast.push_back(pl);
  endtask

  task automatic clear_exp();
    exp_data.delete();
    exp_last.delete();
    exp_plast.delete();
  endtask

  // Starts a job, streams it to completion and compares the accepted words.
  task automatic run_job(input string tag, input logic [5:0] b, input logic [6:0] nw,
                         input logic [7:0] np, input int exp_cycles);
    bit          seen;
    bit          stall;
    logic [15:0] hold_d;
    logic [5:0]  hold_a;
    int          n;
    got_data.delete();
    got_last.delete();
    got_plast.delete();
    base_addr  = b;
    num_words  = nw;
    num_passes = np;
    w_ready    = 1'b1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    base_addr  = 6'h2A;
    num_words  = 7'd5;
    num_passes = 8'd9;
    chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_addr_after_start"}, {26'd0, mem_addr}, {26'd0, b});
    chk({tag, "_valid_after_start"}, {31'd0, w_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      w_ready = (k < rdy_pat.size()) ? rdy_pat[k] : 1'b1;
      start   = (k == poke_at);
      if (k == poke_at) begin
        base_addr  = 6'd0;
        num_words  = 7'd1;
        num_passes = 8'd1;
      end
      if (w_valid && w_ready) begin
        got_data.push_back(w_data);
        got_last.push_back(w_last);
        got_plast.push_back(w_pass_last);
        $display("%s xfer data=%h last=%0b pass_last=%0b", tag, w_data, w_last, w_pass_last);
      end
      stall  = w_valid && !w_ready;
      hold_d = w_data;
      hold_a = mem_addr;
      tick();
      start = 1'b0;
      if (stall) begin
        chk({tag, "_stall_valid"}, {31'd0, w_valid}, 32'd1);
        chk({tag, "_stall_data"}, {16'd0, w_data}, {16'd0, hold_d});
        chk({tag, "_stall_addr"}, {26'd0, mem_addr}, {26'd0, hold_a});
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid_at_done"}, {31'd0, w_valid}, 32'd0);
        if (exp_cycles >= 0)
          chk({tag, "_done_latency"}, k + 1, exp_cycles);
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    tick();
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_word_count"}, got_data.size(), exp_data.size());
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), {16'd0, got_data[i]}, {16'd0, exp_data[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]}, {31'd0, exp_last[i]});
      chk($sformatf("%s_plast%0d", tag, i), {31'd0, got_plast[i]}, {31'd0, exp_plast[i]});
    end
    rdy_pat.delete();
    poke_at = -1;
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    num_words  = '0;
    num_passes = '0;
    w_ready    = 1'b0;
    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_valid", {31'd0, w_valid}, 32'd0);
    chk("reset_last", {30'd0, w_last, w_pass_last}, 32'd0);
    chk("reset_data", {16'd0, w_data}, 32'd0);
    chk("reset_addr", {26'd0, mem_addr}, 32'd0);
    rst = 1'b1;
    tick();

    // Single pass, streaming at full rate.
    clear_exp();
    add_exp(16'h0102, 1'b0, 1'b0);
    add_exp(16'h0103, 1'b0, 1'b0);
    add_exp(16'h0104, 1'b0, 1'b0);
    add_exp(16'h0105, 1'b1, 1'b1);
    run_job("basic", 6'd2, 7'd4, 8'd1, 5);

    // Address wrap with two passes.
    clear_exp();
    add_exp(16'h013E, 1'b0, 1'b0);
    add_exp(16'h013F, 1'b0, 1'b0);
    add_exp(16'h0100, 1'b0, 1'b0);
    add_exp(16'h0101, 1'b1, 1'b0);
    add_exp(16'h013E, 1'b0, 1'b0);
    add_exp(16'h013F, 1'b0, 1'b0);
    add_exp(16'h0100, 1'b0, 1'b0);
    add_exp(16'h0101, 1'b1, 1'b1);
    run_job("wrap", 6'd62, 7'd4, 8'd2, 9);

    // Backpressure.
    clear_exp();
    add_exp(16'h0100, 1'b0, 1'b0);
    add_exp(16'h0101, 1'b0, 1'b0);
    add_exp(16'h0102, 1'b1, 1'b1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_job("bp", 6'd0, 7'd3, 8'd1, -1);

    // Degenerate jobs.
    clear_exp();
    run_job("zero_words", 6'd7, 7'd0, 8'd3, 1);
    run_job("zero_passes", 6'd7, 7'd4, 8'd0, 1);

    // Full depth with a start pulse issued mid-job.
    clear_exp();
    for (int i = 0; i < 64; i++)
      add_exp(16'h0100 + 16'((10 + i) % 64), i == 63, i == 63);
    poke_at = 10;
    run_job("full", 6'd10, 7'd64, 8'd1, 65);
    tick();
    tick();
    chk("full_poke_ignored_busy", {31'd0, busy}, 32'd0);
    chk("full_poke_ignored_valid", {31'd0, w_valid}, 32'd0);

    // Reset after the second handshake.
    base_addr  = 6'd0;
    num_words  = 7'd8;
    num_passes = 8'd1;
    w_ready    = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid_first_word", {16'd0, w_data}, 32'h0100);
    tick();
    chk("rst_mid_second_word", {16'd0, w_data}, 32'h0101);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mid_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", {26'd0, mem_addr}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    tick();
    chk("rst_mid_no_done", {31'd0, done}, 32'd0);
    chk("rst_mid_still_idle", {31'd0, busy}, 32'd0);

    clear_exp();
    add_exp(16'h0105, 1'b0, 1'b0);
    add_exp(16'h0106, 1'b1, 1'b1);
    run_job("after_rst", 6'd5, 7'd2, 8'd1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
